// File: rtl/fpadd_pkg.sv
// Shared definitions for the fpadd front end: precision/opcode encodings,
// exponent re-bias constants and the operand queue entry layout.
package fpadd_pkg;

    localparam logic [1:0] PREC_DP = 2'b00;
    localparam logic [1:0] PREC_SP = 2'b01;
    localparam logic [1:0] PREC_HP = 2'b11;

    localparam logic [2:0] OP_ABS = 3'b100;
    localparam logic [2:0] OP_NEG = 3'b101;

    localparam logic [10:0] SP_TO_DP_BIAS = 11'd896;
    localparam logic [10:0] HP_TO_DP_BIAS = 11'd1008;

    typedef struct packed {
        logic [63:0] float1;
        logic [63:0] float2;
        logic [2:0]  op_type;
        logic [1:0]  p;
    } fpadd_entry_t;

endpackage

// File: rtl/fpadd_widen.sv
// Combinational widener: re-lays a single- or half-precision operand into
// double-precision exponent/fraction fields (sign handled by the caller).
module fpadd_widen
    import fpadd_pkg::*;
(
    input  logic [62:0] op,
    input  logic        conv_sp,
    input  logic        conv_hp,
    output logic [62:0] exp_frac
);

    logic [7:0]  sp_e;
    logic [4:0]  hp_e;
    logic [10:0] e11;

    assign sp_e = op[62:55];
    assign hp_e = op[62:58];

    // Zero and all-ones exponents map to their DP counterparts; denormal
    // fractions are copied unnormalised.
    always_comb begin
        e11      = '0;
        exp_frac = op;
        if (conv_hp) begin
            if (hp_e == 5'h00) begin
                e11 = 11'h000;
            end else if (hp_e == 5'h1f) begin
                e11 = 11'h7ff;
            end else begin
                e11 = {6'b0, hp_e} + HP_TO_DP_BIAS;
            end
            exp_frac = {e11, op[57:48], 42'b0};
        end else if (conv_sp) begin
            if (sp_e == 8'h00) begin
                e11 = 11'h000;
            end else if (sp_e == 8'hff) begin
                e11 = 11'h7ff;
            end else begin
                e11 = {3'b0, sp_e} + SP_TO_DP_BIAS;
            end
            exp_frac = {e11, op[54:32], 29'b0};
        end
    end

endmodule

// File: rtl/fpadd_input_stage.sv
// Operand converter for fpadd followed by a DEPTH-entry elastic queue;
// in_ready/out_valid/count depend only on registered state.
module fpadd_input_stage
    import fpadd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              op1,
    input  logic [63:0]              op2,
    input  logic [2:0]               op_type,
    input  logic [1:0]               P,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              Float1,
    output logic [63:0]              Float2,
    output logic [2:0]               out_op_type,
    output logic [1:0]               out_P,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          x_sel;
    logic          conv_hp;
    logic          conv_sp;
    logic          negate;
    logic          abs_val;
    logic [62:0]   mag1;
    logic [62:0]   mag2;
    fpadd_entry_t  entry_in;

    assign x_sel   = op_type[2] & op_type[1];
    assign conv_hp = (P == PREC_HP) & ~x_sel;
    assign conv_sp = ~conv_hp & (x_sel ^ P[0]);
    assign negate  = (op_type == OP_NEG);
    assign abs_val = (op_type == OP_ABS);

    fpadd_widen u_widen1 (
        .op       (op1[62:0]),
        .conv_sp  (conv_sp),
        .conv_hp  (conv_hp),
        .exp_frac (mag1)
    );

    fpadd_widen u_widen2 (
        .op       (op2[62:0]),
        .conv_sp  (conv_sp),
        .conv_hp  (conv_hp),
        .exp_frac (mag2)
    );

    assign entry_in.float1  = {(op1[63] ^ negate) & ~abs_val, mag1};
    assign entry_in.float2  = {op2[63], mag2};
    assign entry_in.op_type = op_type;
    assign entry_in.p       = P;

    fpadd_entry_t   mem_q [DEPTH];
    fpadd_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push;
    logic           pop;

    // Full blocks input even if the head pops this cycle: no out_ready->in_ready path.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush & ~reset;
    assign pop       = out_valid & out_ready & ~flush & ~reset;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry_in;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign Float1      = mem_q[rd_ptr_q].float1;
    assign Float2      = mem_q[rd_ptr_q].float2;
    assign out_op_type = mem_q[rd_ptr_q].op_type;
    assign out_P       = mem_q[rd_ptr_q].p;
    assign count       = count_q;

endmodule

// File: tb/tb_fpadd_input_stage.sv
// Bench for fpadd_input_stage: directed spec vectors plus random traffic,
// compared against a queue-based model of conversion and flow control.
module tb_fpadd_input_stage;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [63:0]            op1;
    logic [63:0]            op2;
    logic [2:0]             op_type;
    logic [1:0]             P;
    logic                   out_valid;
    logic                   out_ready;
    logic [63:0]            Float1;
    logic [63:0]            Float2;
    logic [2:0]             out_op_type;
    logic [1:0]             out_P;
    logic [$clog2(DEPTH):0] count;

    int checks;
    int failures;
    int accepted;
    logic [132:0] exp_q[$];

    fpadd_input_stage #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op1         (op1),
        .op2         (op2),
        .op_type     (op_type),
        .P           (P),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Float1      (Float1),
        .Float2      (Float2),
        .out_op_type (out_op_type),
        .out_P       (out_P),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [62:0] m_widen(input logic [63:0] op, input bit sp, input bit hp);
        int e;
        logic [10:0] oe;
        logic [62:0] r;
        r = op[62:0];
        if (hp) begin
            e = int'(op[62:58]);
            if (e == 0) oe = 11'd0;
            else if (e == 31) oe = 11'd2047;
            else oe = 11'(e + 1008);
            r = {oe, op[57:48], 42'd0};
        end else if (sp) begin
            e = int'(op[62:55]);
            if (e == 0) oe = 11'd0;
            else if (e == 255) oe = 11'd2047;
            else oe = 11'(e + 896);
            r = {oe, op[54:32], 29'd0};
        end
        return r;
    endfunction

    function automatic logic [132:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] t, input logic [1:0] p);
        bit x;
        bit hp;
        bit sp;
        bit s1;
        x  = t[2] & t[1];
        hp = (p == 2'b11) && !x;
        sp = !hp && (x ^ p[0]);
        s1 = (a[63] ^ (t == 3'b101)) & ~(t == 3'b100);
        return {s1, m_widen(a, sp, hp), b[63], m_widen(b, sp, hp), t, p};
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v[62:55] = 8'h00;
            1: v[62:55] = 8'hff;
            2: v[62:58] = 5'h00;
            3: v[62:58] = 5'h1f;
            default: ;
        endcase
        return v;
    endfunction

    // One clock: drive inputs, compare against the model mid-cycle, advance the model.
    task automatic cycle(input bit iv, input bit ordy, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] t, input logic [1:0] p, input bit fl, input bit rs);
        logic [132:0] e;
        bit m_ready;
        bit m_valid;
        in_valid  = iv;
        out_ready = ordy;
        op1       = a;
        op2       = b;
        op_type   = t;
        P         = p;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        m_ready = exp_q.size() < DEPTH;
        m_valid = exp_q.size() > 0;
        check("in_ready", 64'(in_ready), 64'(m_ready));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("count", 64'(count), 64'(exp_q.size()));
        check("count_le_depth", 64'(int'(count) <= DEPTH), 64'd1);
        if (m_valid) begin
            e = exp_q[0];
            check("float1", Float1, e[132:69]);
            check("float2", Float2, e[68:5]);
            check("out_op_type", 64'(out_op_type), 64'(e[4:2]));
            check("out_P", 64'(out_P), 64'(e[1:0]));
        end
        if (rs || fl) begin
            exp_q.delete();
        end else begin
            if (m_valid && ordy) void'(exp_q.pop_front());
            if (m_ready && iv) begin
                exp_q.push_back(model(a, b, t, p));
                accepted++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, ordy, 64'd0, 64'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int acc0;
        checks    = 0;
        failures  = 0;
        accepted  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = '0;
        op2       = '0;
        op_type   = '0;
        P         = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);

        // SP widen
        cycle(1'b1, 1'b1, 64'h3F80000000000000, 64'h7F80000000000000, 3'b000, 2'b01, 1'b0, 1'b0);
        check("sp_valid", 64'(out_valid), 64'd1);
        check("sp_f1", Float1, 64'h3FF0000000000000);
        check("sp_f2", Float2, 64'h7FF0000000000000);

        // HP widen
        cycle(1'b1, 1'b1, 64'h3C00000000000000, 64'h0, 3'b000, 2'b11, 1'b0, 1'b0);
        check("hp_f1", Float1, 64'h3FF0000000000000);

        // SP denormal
        cycle(1'b1, 1'b1, 64'h0040000000000000, 64'h0, 3'b000, 2'b01, 1'b0, 1'b0);
        check("sp_denorm_f1", Float1, 64'h0008000000000000);

        // Negate and absolute value on DP operands
        cycle(1'b1, 1'b1, 64'h4000000000000000, 64'hC000000000000000, 3'b101, 2'b00, 1'b0, 1'b0);
        check("neg_f1", Float1, 64'hC000000000000000);
        check("neg_f2", Float2, 64'hC000000000000000);
        cycle(1'b1, 1'b1, 64'hC000000000000000, 64'h4000000000000000, 3'b100, 2'b00, 1'b0, 1'b0);
        check("abs_f1", Float1, 64'h4000000000000000);
        check("abs_f2", Float2, 64'h4000000000000000);
        idle(1'b1);

        // Backpressure: six offers with the consumer stalled
        acc0 = accepted;
        repeat (6) cycle(1'b1, 1'b0, rand_op(), rand_op(), 3'($urandom_range(0, 7)),
                         2'($urandom_range(0, 3)), 1'b0, 1'b0);
        check("bp_accepted", 64'(accepted - acc0), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_count", 64'(count), 64'd4);
        repeat (4) idle(1'b1);
        check("bp_drained_ready", 64'(in_ready), 64'd1);
        check("bp_drained_count", 64'(count), 64'd0);

        // Back-to-back with toggling consumer
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'(i % 2), rand_op(), rand_op(), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'b0, 1'b0);
        repeat (6) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_op(), rand_op(),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        repeat (6) idle(1'b1);

        // Flush with three entries queued and a push offered
        repeat (3) cycle(1'b1, 1'b0, rand_op(), rand_op(), 3'd0, 2'd1, 1'b0, 1'b0);
        check("pre_flush_count", 64'(count), 64'd3);
        cycle(1'b1, 1'b0, rand_op(), rand_op(), 3'd0, 2'd0, 1'b1, 1'b0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        idle(1'b0);

        // Same with reset
        repeat (3) cycle(1'b1, 1'b0, rand_op(), rand_op(), 3'd0, 2'd3, 1'b0, 1'b0);
        check("pre_reset_count", 64'(count), 64'd3);
        cycle(1'b1, 1'b0, rand_op(), rand_op(), 3'd0, 2'd0, 1'b0, 1'b1);
        check("reset_count", 64'(count), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        idle(1'b0);

        // Queue keeps working after reset
        repeat (5) cycle(1'b1, 1'b1, rand_op(), rand_op(), 3'($urandom_range(0, 7)),
                         2'($urandom_range(0, 3)), 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
